regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the 8x32 single-write register file.
- Provides two combinational read ports and two synchronous write ports with fixed priority.
- Optional same-cycle write-to-read bypass and optional hard-wired-zero R0.
- Adds a per-register busy scoreboard for the pipelined datapath, plus a post-reset clear sweep so the array can map to RAM.
- Sits between decode (read/issue) and writeback (write ports).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 8, number of registers; power of two, >= 2
ADDR_W, $clog2(NUM_REGS), address width (derived)
ZERO_R0, 1, 1 = R0 reads 0, ignores writes, never goes busy
BYPASS, 1, 1 = a read of an address being written this cycle returns the new data

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
ready  output  1  high once the clear sweep has finished
we0  input  1  write enable, port 0
wa0  input  ADDR_W  write address, port 0
wd0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1 (higher priority)
wa1  input  ADDR_W  write address, port 1
wd1  input  DATA_W  write data, port 1
RA1  input  ADDR_W  read address 1
RA2  input  ADDR_W  read address 2
RD1  output  DATA_W  read data 1 (combinational)
RD2  output  DATA_W  read data 2 (combinational)
busy1  output  1  busy bit of RA1 (combinational)
busy2  output  1  busy bit of RA2 (combinational)
issue_valid  input  1  mark issue_dest busy
issue_dest  input  ADDR_W  destination of the issuing instruction
issue_stall  output  1  busy bit of issue_dest (combinational)

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-high.
- FSM states: INIT and RUN.
- Reset: on any edge with reset=1, the block enters INIT and sets sweep index to 0, ready=0 and all busy bits to 0. Registered outputs take these values on the first edge with reset=1. A reset asserted mid-sweep restarts the sweep at index 0.
- INIT sweep:
  - Each cycle writes 0 to registers[index] and increments index.
  - After index NUM_REGS-1 is written, the next state is RUN and ready=1.
  - The sweep lasts exactly NUM_REGS cycles after reset deasserts.
- Behaviour while in INIT:
  - we0, we1 and issue_valid are ignored.
  - RD1, RD2, busy1, busy2 and issue_stall are forced to 0.
- Writes (RUN only):
  - Take effect on the rising edge when weN=1.
  - If both ports target the same address, wd1 is stored.
  - With ZERO_R0=1, writes to address 0 are dropped.
- Reads:
  - RDx = registers[RAx], purely combinational.
  - With ZERO_R0=1, RAx==0 returns 0 regardless of bypass.
  - With BYPASS=1 and a RUN-state write to RAx this cycle, RDx = wd1 if we1 && wa1==RAx, else wd0. This applies to both ports independently.
  - With BYPASS=0, the old value is returned until the edge.
- Scoreboard, one busy bit per register:
  - Set on an edge with RUN && issue_valid, at issue_dest (except address 0 when ZERO_R0=1).
  - Cleared on an edge with RUN && weN at waN, for either port.
  - If set and clear hit the same register on the same edge, set wins: the new producer replaces the old one.
  - Setting an already-busy register is legal and keeps it busy.
- issue_stall: reports the current busy[issue_dest]. It does not gate the set; decode must hold issue_valid low while issue_stall=1.
- Latency: write to readback is 0 cycles with BYPASS=1 and 1 cycle otherwise. Busy set/clear is visible 1 cycle after the edge.

Test Plan:
- Reset, then init: hold reset 3 cycles, release. ready=0 for exactly 8 cycles, then 1. All RD reads return 0x0 and busy reads return 0.
- Write/read with BYPASS=1: we0=1, wa0=3, wd0=0xAAAA0003. RD1 with RA1=3 shows 0xAAAA0003 in the same cycle and holds it after we0 drops.
- Priority: we0 (wa0=5, wd0=0x11) and we1 (wa1=5, wd1=0x22) in the same cycle. RD2 with RA2=5 reads 0x22, both during the cycle and afterwards.
- R0: we1=1, wa1=0, wd1=0xFFFFFFFF, and issue_valid with issue_dest=0. RD1 with RA1=0 reads 0, and issue_stall=0 when issue_dest=0.
- Scoreboard: issue_dest=4 raises busy1 (RA1=4) next cycle. Then a simultaneous we0 to 4 and issue_dest=4 leaves it busy. A later we1 to 4 alone clears it.
- Mid-sweep reset: assert reset at sweep cycle 5 after an earlier write of 0x55 to R7. ready stays 0 for a further 8 cycles, and R7 reads 0x0 after ready rises.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised 2R/2W register file with per-register busy scoreboard.
// After reset the array is cleared by a one-entry-per-cycle sweep so it can map to RAM;
// ready rises once the sweep completes.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_R0  = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              ready,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy1,
  output logic              busy2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_stall
);

  typedef enum logic {StInit, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                ready_q, ready_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];

  logic run;
  logic wr0_ok, wr1_ok, set_ok;

  assign run    = (state_q == StRun);
  // Writes to R0 are dropped when it is hard-wired to zero; R0 also never goes busy.
  assign wr0_ok = run && we0 && !(ZERO_R0 && (wa0 == '0));
  assign wr1_ok = run && we1 && !(ZERO_R0 && (wa1 == '0));
  assign set_ok = run && issue_valid && !(ZERO_R0 && (issue_dest == '0));

  // Next-state: clear sweep in StInit, prioritised writes and scoreboard update in StRun.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    if (reset) begin
      state_d = StInit;
      idx_d   = '0;
      ready_d = 1'b0;
      busy_d  = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          mem_d[idx_q] = '0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end
        StRun: begin
          // Port 1 is applied last so it wins an address collision.
          if (wr0_ok) mem_d[wa0] = wd0;
          if (wr1_ok) mem_d[wa1] = wd1;
          if (we0) busy_d[wa0] = 1'b0;
          if (we1) busy_d[wa1] = 1'b0;
          // Set after clear: a new producer replaces the one being retired.
          if (set_ok) busy_d[issue_dest] = 1'b1;
        end
      endcase
    end
  end

  // State register; the array itself is not reset, the sweep clears it.
  always_ff @(posedge CLOCK_50) begin
    state_q <= state_d;
    idx_q   <= idx_d;
    ready_q <= ready_d;
    busy_q  <= busy_d;
    mem_q   <= mem_d;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = mem_q[ra];
    if (BYPASS && run && we1 && (wa1 == ra)) begin
      val = wd1;
    end else if (BYPASS && run && we0 && (wa0 == ra)) begin
      val = wd0;
    end
    if (!run || (ZERO_R0 && (ra == '0))) begin
      val = '0;
    end
    return val;
  endfunction

  // Combinational read ports and scoreboard lookups, forced low during the sweep.
  always_comb begin
    RD1         = read_port(RA1);
    RD2         = read_port(RA2);
    busy1       = run && busy_q[RA1];
    busy2       = run && busy_q[RA2];
    issue_stall = run && busy_q[issue_dest];
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized checks of regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        ready;
  logic        we0, we1, issue_valid;
  logic [2:0]  wa0, wa1, RA1, RA2, issue_dest;
  logic [31:0] wd0, wd1, RD1, RD2;
  logic        busy1, busy2, issue_stall;

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural model
  logic [31:0] m_mem [8];
  bit          m_busy [8];
  bit          m_ready = 1'b0;
  int          m_left = 8;

  always #5 CLOCK_50 = ~CLOCK_50;

  regfile_scoreboard dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .ready      (ready),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .RA1        (RA1),
    .RA2        (RA2),
    .RD1        (RD1),
    .RD2        (RD2),
    .busy1      (busy1),
    .busy2      (busy2),
    .issue_valid(issue_valid),
    .issue_dest (issue_dest),
    .issue_stall(issue_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] ra);
    if (!m_ready || ra == 3'd0) return 32'h0;
    if (we1 && wa1 == ra) return wd1;
    if (we0 && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [2:0] ra);
    return m_ready ? m_busy[ra] : 1'b0;
  endfunction

  // Advance one clock and apply the specification's rules to the model.
  task automatic tick();
    @(posedge CLOCK_50);
    if (reset) begin
      m_ready = 1'b0;
      m_left  = 8;
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
        m_ready = 1'b1;
      end
    end else begin
      if (we0 && wa0 != 3'd0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 3'd0) m_mem[wa1] = wd1;
      if (we0) m_busy[wa0] = 1'b0;
      if (we1) m_busy[wa1] = 1'b0;
      if (issue_valid && issue_dest != 3'd0) m_busy[issue_dest] = 1'b1;
    end
    #1;
  endtask

  task automatic check_all();
    #1;
    check("rd1", RD1, exp_rd(RA1));
    check("rd2", RD2, exp_rd(RA2));
    check("busy1", {31'b0, busy1}, {31'b0, exp_busy(RA1)});
    check("busy2", {31'b0, busy2}, {31'b0, exp_busy(RA2)});
    check("stall", {31'b0, issue_stall}, {31'b0, exp_busy(issue_dest)});
    check("ready", {31'b0, ready}, {31'b0, m_ready});
  endtask

  task automatic idle();
    we0 = 0; wa0 = 0; wd0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0;
    RA1 = 0; RA2 = 0;
    issue_valid = 0; issue_dest = 0;
  endtask

  // Release reset and measure sweep length with a cycle bound.
  task automatic release_and_sweep(input string tag);
    int n;
    reset = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      check_all();
      tick();
      n++;
    end
    check(tag, n, 8);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    idle();
    reset = 1'b1;

    // Reset for 3 cycles, then the clear sweep.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all();
      check("rst_ready", {31'b0, ready}, 32'h0);
    end
    release_and_sweep("init_len");
    for (int r = 0; r < 8; r++) begin
      RA1 = 3'(r); RA2 = 3'(r);
      check_all();
      check("clr_rd1", RD1, 32'h0);
      check("clr_busy1", {31'b0, busy1}, 32'h0);
    end

    // Write with bypass.
    idle();
    we0 = 1; wa0 = 3; wd0 = 32'hAAAA0003; RA1 = 3;
    #1 check("byp_rd1", RD1, 32'hAAAA0003);
    tick();
    we0 = 0;
    #1 check("hold_rd1", RD1, 32'hAAAA0003);

    // Port 1 priority on a collision.
    we0 = 1; wa0 = 5; wd0 = 32'h11;
    we1 = 1; wa1 = 5; wd1 = 32'h22; RA2 = 5;
    #1 check("prio_byp", RD2, 32'h22);
    tick();
    idle(); RA2 = 5;
    #1 check("prio_hold", RD2, 32'h22);

    // R0 hard-wired zero and never busy.
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; issue_valid = 1; issue_dest = 0; RA1 = 0;
    #1 check("r0_byp", RD1, 32'h0);
    tick();
    idle();
    #1 check("r0_rd", RD1, 32'h0);
    check("r0_stall", {31'b0, issue_stall}, 32'h0);
    check("r0_busy", {31'b0, busy1}, 32'h0);

    // Scoreboard set, set-wins-over-clear, then clear.
    issue_valid = 1; issue_dest = 4; RA1 = 4;
    #1 check("sb_pre", {31'b0, busy1}, 32'h0);
    tick();
    issue_valid = 0;
    #1 check("sb_set", {31'b0, busy1}, 32'h1);
    check("sb_stall", {31'b0, issue_stall}, 32'h1);
    we0 = 1; wa0 = 4; wd0 = 32'h44; issue_valid = 1; issue_dest = 4;
    tick();
    idle(); RA1 = 4;
    #1 check("sb_setwins", {31'b0, busy1}, 32'h1);
    we1 = 1; wa1 = 4; wd1 = 32'h45;
    tick();
    idle(); RA1 = 4;
    #1 check("sb_clr", {31'b0, busy1}, 32'h0);
    check("sb_data", RD1, 32'h45);
    check_all();

    // Mid-sweep reset.
    we0 = 1; wa0 = 7; wd0 = 32'h55;
    tick();
    idle(); RA1 = 7;
    #1 check("r7_wr", RD1, 32'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_all();
      tick();
    end
    reset = 1'b1;
    tick();
    release_and_sweep("resweep_len");
    RA1 = 7;
    check_all();
    check("r7_clr", RD1, 32'h0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 63) == 0);
      we0         = $urandom_range(0, 1);
      wa0         = 3'($urandom);
      wd0         = $urandom;
      we1         = $urandom_range(0, 1);
      wa1         = ($urandom_range(0, 3) == 0) ? wa0 : 3'($urandom);
      wd1         = $urandom;
      RA1         = ($urandom_range(0, 2) == 0) ? wa1 : 3'($urandom);
      RA2         = ($urandom_range(0, 2) == 0) ? wa0 : 3'($urandom);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_dest  = 3'($urandom);
      check_all();
      tick();
    end
    reset = 1'b0;
    idle();
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
